// File: rtl/pix_stream_framer.sv
// pix_stream_framer: buffers the filter's pixel stream in a FIFO and re-emits it as a framed
// AXI4-Stream with SOF on tuser, per-line tlast, line counting and an end-of-frame pulse.
module pix_stream_framer #(
    parameter int NUM_PIX    = 640,
    parameter int NUM_LINE   = 512,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [7:0]  axis_tdata_i,
    input  logic        axis_tvalid_i,
    input  logic        axis_tkeep_i,
    input  logic        axis_tlast_i,
    output logic [15:0] axis_tdata_o,
    output logic        axis_tvalid_o,
    input  logic        axis_tready_i,
    output logic [1:0]  axis_tkeep_o,
    output logic        axis_tlast_o,
    output logic        axis_tuser_o,
    output logic        frame_done_o,
    output logic [15:0] line_cnt_o,
    output logic        err_len_o,
    output logic        err_ovf_o
);
    localparam int PW = $clog2(NUM_PIX);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PIX_LAST  = PW'(NUM_PIX - 1);
    localparam logic [15:0]   LINE_LAST = 16'(NUM_LINE - 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_LINE = 2'd1, S_GAP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [15:0]   line_cnt_q, line_cnt_d, out_line_q, out_line_d, out_base;
    logic [9:0]    in_q, in_d, out_q, out_d;
    logic          in_vld_q, in_vld_d, out_vld_q, out_vld_d;
    logic          err_len_q, err_len_d, err_ovf_q, err_ovf_d, frame_done_q, frame_done_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic          acc, pix_last, line_last, eol, empty, full, rd, wr, hs, out_last;

    // Entries are {sof, eol, pix}; the input beat is registered once before the FIFO write.
    always_comb begin
        acc          = axis_tvalid_i & axis_tkeep_i;
        pix_last     = pix_cnt_q == PIX_LAST;
        line_last    = line_cnt_q == LINE_LAST;
        eol          = axis_tlast_i | pix_last;
        in_vld_d     = acc;
        in_d         = {state_q == S_IDLE, eol, axis_tdata_i};
        pix_cnt_d    = !acc ? pix_cnt_q : eol ? '0 : pix_cnt_q + 1'b1;
        line_cnt_d   = !(acc & eol) ? line_cnt_q : line_last ? '0 : line_cnt_q + 16'd1;
        state_d      = !acc ? state_q : !eol ? S_LINE : line_last ? S_IDLE : S_GAP;
        err_len_d    = err_len_q | (acc & (axis_tlast_i ^ pix_last));
        empty        = wr_ptr_q == rd_ptr_q;
        full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd           = !empty && (!out_vld_q || axis_tready_i);
        wr           = in_vld_q && (!full || rd);
        err_ovf_d    = err_ovf_q | (in_vld_q & ~wr);
        wr_ptr_d     = wr_ptr_q + (AW+1)'(wr);
        rd_ptr_d     = rd_ptr_q + (AW+1)'(rd);
        out_vld_d    = (!out_vld_q || axis_tready_i) ? !empty : out_vld_q;
        out_d        = rd ? mem_q[rd_ptr_q[AW-1:0]] : out_q;
        hs           = out_vld_q & axis_tready_i;
        out_base     = out_q[9] ? '0 : out_line_q;
        out_last     = out_q[8] && out_base == LINE_LAST;
        frame_done_d = hs & out_last;
        out_line_d   = !hs ? out_line_q : !out_q[8] ? out_base : out_last ? '0 : out_base + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            out_line_q   <= '0;
            in_q         <= '0;
            in_vld_q     <= 1'b0;
            out_q        <= '0;
            out_vld_q    <= 1'b0;
            err_len_q    <= 1'b0;
            err_ovf_q    <= 1'b0;
            frame_done_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            out_line_q   <= out_line_d;
            in_q         <= in_d;
            in_vld_q     <= in_vld_d;
            out_q        <= out_d;
            out_vld_q    <= out_vld_d;
            err_len_q    <= err_len_d;
            err_ovf_q    <= err_ovf_d;
            frame_done_q <= frame_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wr_ptr_q[AW-1:0]] <= in_q;
    end

    assign axis_tdata_o  = {8'h00, out_q[7:0]};
    assign axis_tvalid_o = out_vld_q;
    assign axis_tkeep_o  = {2{out_vld_q}};
    assign axis_tlast_o  = out_q[8];
    assign axis_tuser_o  = out_q[9];
    assign frame_done_o  = frame_done_q;
    assign line_cnt_o    = line_cnt_q;
    assign err_len_o     = err_len_q;
    assign err_ovf_o     = err_ovf_q;
endmodule

// File: tb/tb_pix_stream_framer.sv
// tb_pix_stream_framer: scoreboard bench for pix_stream_framer on a reduced 16x4 frame
// with a 16-entry FIFO.
module tb_pix_stream_framer;
    localparam int NP = 16, NL = 4, FD = 16;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [7:0]  axis_tdata_i = '0;
    logic        axis_tvalid_i = 1'b0, axis_tkeep_i = 1'b0, axis_tlast_i = 1'b0;
    logic        axis_tready_i = 1'b0;
    logic [15:0] axis_tdata_o, line_cnt_o;
    logic [1:0]  axis_tkeep_o;
    logic        axis_tvalid_o, axis_tlast_o, axis_tuser_o, frame_done_o, err_len_o, err_ovf_o;

    int tests = 0, fails = 0, fd_cnt = 0, m_pix = 0, m_line = 0;
    logic [10:0] exp_q[$];
    logic [10:0] e;
    logic fd_pend = 1'b0;

    always #5 clk_i = ~clk_i;

    pix_stream_framer #(.NUM_PIX(NP), .NUM_LINE(NL), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .axis_tdata_i(axis_tdata_i), .axis_tvalid_i(axis_tvalid_i),
        .axis_tkeep_i(axis_tkeep_i), .axis_tlast_i(axis_tlast_i),
        .axis_tdata_o(axis_tdata_o), .axis_tvalid_o(axis_tvalid_o),
        .axis_tready_i(axis_tready_i), .axis_tkeep_o(axis_tkeep_o),
        .axis_tlast_o(axis_tlast_o), .axis_tuser_o(axis_tuser_o),
        .frame_done_o(frame_done_o), .line_cnt_o(line_cnt_o),
        .err_len_o(err_len_o), .err_ovf_o(err_ovf_o)
    );

    // Output monitor: a beat shown at the negedge with tready high is taken at the next posedge.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            fd_pend = 1'b0;
        end else begin
            if (frame_done_o) fd_cnt++;
            if (fd_pend || frame_done_o) begin
                tests++;
                if (frame_done_o !== fd_pend) begin
                    fails++;
                    $display("FAIL frame_done: got %b want %b", frame_done_o, fd_pend);
                end
            end
            fd_pend = 1'b0;
            if (axis_tvalid_o) begin
                tests++;
                if (axis_tkeep_o !== 2'b11) begin
                    fails++;
                    $display("FAIL tkeep: got %b want 11", axis_tkeep_o);
                end
            end
            if (axis_tvalid_o && axis_tready_i) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got data %h, none expected", axis_tdata_o);
                end else begin
                    e = exp_q.pop_front();
                    fd_pend = e[10];
                    if ({axis_tuser_o, axis_tlast_o, axis_tdata_o} !== {e[9], e[8], 8'h00, e[7:0]}) begin
                        fails++;
                        $display("FAIL beat: got user=%b last=%b data=%h want user=%b last=%b data=%h",
                                 axis_tuser_o, axis_tlast_o, axis_tdata_o, e[9], e[8], {8'h00, e[7:0]});
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] pix, input logic last, input logic keep, input bit push);
        logic sof, eol, fd;
        axis_tdata_i = pix; axis_tlast_i = last; axis_tkeep_i = keep; axis_tvalid_i = 1'b1;
        if (keep) begin
            sof = m_pix == 0 && m_line == 0;
            eol = last || m_pix == NP - 1;
            fd  = eol && m_line == NL - 1;
            if (push) exp_q.push_back({fd, sof, eol, pix});
            m_pix = eol ? 0 : m_pix + 1;
            if (eol) m_line = (m_line == NL - 1) ? 0 : m_line + 1;
        end
        idle(1);
        axis_tvalid_i = 1'b0; axis_tkeep_i = 1'b0; axis_tlast_i = 1'b0;
    endtask

    task automatic send_line(input int n, input logic [7:0] base, input bit with_last, input int gap);
        for (int i = 0; i < n; i++) beat(base + 8'(i), with_last && i == n - 1, 1'b1, 1'b1);
        idle(gap);
    endtask

    task automatic do_reset();
        rstn_i = 1'b0;
        idle(1);
        rstn_i = 1'b1;
        exp_q.delete();
        m_pix = 0; m_line = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            idle(1);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s drain: %0d beats still missing, want 0", name, exp_q.size());
        end
        idle(3);
    endtask

    task automatic test_reset();
        idle(2);
        tests++;
        if ({axis_tvalid_o, axis_tdata_o, axis_tkeep_o, axis_tlast_o, axis_tuser_o, frame_done_o,
             line_cnt_o, err_len_o, err_ovf_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%b d=%h k=%b l=%b u=%b fd=%b lc=%0d el=%b eo=%b, want all 0",
                     axis_tvalid_o, axis_tdata_o, axis_tkeep_o, axis_tlast_o, axis_tuser_o,
                     frame_done_o, line_cnt_o, err_len_o, err_ovf_o);
        end
        rstn_i = 1'b1;
        idle(1);
    endtask

    task automatic test_latency();
        int seen = 0;
        do_reset();
        axis_tready_i = 1'b1;
        beat(8'hA5, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            if (axis_tvalid_o && seen == 0) seen = i;
            idle(1);
        end
        tests++;
        if (seen != 3) begin
            fails++;
            $display("FAIL latency: tvalid_o seen %0d ns-after-edge steps, want at edge N+2", seen);
        end
        drain("latency");
    endtask

    task automatic test_frame();
        int fd0;
        do_reset();
        axis_tready_i = 1'b1;
        fd0 = fd_cnt;
        for (int l = 0; l < NL; l++) send_line(NP, 8'(l * 16), 1'b1, 5);
        drain("frame");
        tests++;
        if (fd_cnt - fd0 != 1 || err_len_o !== 1'b0 || err_ovf_o !== 1'b0 || line_cnt_o !== 16'd0) begin
            fails++;
            $display("FAIL frame_end: got done=%0d el=%b eo=%b lc=%0d want 1 0 0 0",
                     fd_cnt - fd0, err_len_o, err_ovf_o, line_cnt_o);
        end
    endtask

    task automatic test_back_to_back();
        int fd0, n = 0;
        do_reset();
        axis_tready_i = 1'b1;
        fd0 = fd_cnt;
        for (int i = 0; i < 2 * NL * NP; i++) beat(8'(i * 3), (i % NP) == NP - 1, 1'b1, 1'b1);
        while (exp_q.size() != 0 && n < 50) begin
            idle(1);
            n++;
        end
        tests++;
        if (n > 3) begin
            fails++;
            $display("FAIL throughput: drain took %0d cycles, want <= 3", n);
        end
        idle(3);
        tests++;
        if (fd_cnt - fd0 != 2 || err_len_o !== 1'b0 || err_ovf_o !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end: got done=%0d el=%b eo=%b want 2 0 0", fd_cnt - fd0, err_len_o, err_ovf_o);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        axis_tready_i = 1'b0;
        for (int i = 0; i < 30; i++) beat(8'(8'h10 + i), (i % NP) == NP - 1, 1'b1, i < FD + 1);
        idle(3);
        tests++;
        if (err_ovf_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flag: got %b want 1", err_ovf_o);
        end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({axis_tvalid_o, axis_tuser_o, axis_tdata_o} !== {1'b1, 1'b1, 16'h0010}) begin
                fails++;
                $display("FAIL ovf_hold: got v=%b u=%b d=%h want 1 1 0010", axis_tvalid_o, axis_tuser_o, axis_tdata_o);
            end
            idle(4);
        end
        axis_tready_i = 1'b1;
        drain("overflow");
        tests++;
        if (err_ovf_o !== 1'b1 || err_len_o !== 1'b0) begin
            fails++;
            $display("FAIL ovf_sticky: got eo=%b el=%b want 1 0", err_ovf_o, err_len_o);
        end
    endtask

    task automatic test_short_line();
        do_reset();
        axis_tready_i = 1'b1;
        send_line(5, 8'h40, 1'b1, 2);
        tests++;
        if (err_len_o !== 1'b1 || line_cnt_o !== 16'd1) begin
            fails++;
            $display("FAIL short_line: got el=%b lc=%0d want 1 1", err_len_o, line_cnt_o);
        end
        send_line(NP, 8'h60, 1'b1, 2);
        tests++;
        if (line_cnt_o !== 16'd2) begin
            fails++;
            $display("FAIL short_next: got lc=%0d want 2", line_cnt_o);
        end
        drain("short");
    endtask

    task automatic test_long_line();
        do_reset();
        axis_tready_i = 1'b1;
        send_line(NP + 4, 8'h80, 1'b0, 2);
        tests++;
        if (err_len_o !== 1'b1 || line_cnt_o !== 16'd1) begin
            fails++;
            $display("FAIL long_line: got el=%b lc=%0d want 1 1", err_len_o, line_cnt_o);
        end
        drain("long");
    endtask

    task automatic test_mid_reset();
        int fd0;
        do_reset();
        axis_tready_i = 1'b1;
        send_line(5, 8'h20, 1'b1, 1);
        send_line(NP, 8'h30, 1'b1, 1);
        send_line(7, 8'h50, 1'b0, 0);
        rstn_i = 1'b0;
        axis_tvalid_i = 1'b1; axis_tkeep_i = 1'b1; axis_tdata_i = 8'hFF;
        idle(1);
        axis_tvalid_i = 1'b0; axis_tkeep_i = 1'b0;
        tests++;
        if ({axis_tvalid_o, axis_tdata_o, axis_tkeep_o, axis_tlast_o, axis_tuser_o, frame_done_o,
             line_cnt_o, err_len_o, err_ovf_o} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: got v=%b d=%h lc=%0d el=%b eo=%b, want all 0",
                     axis_tvalid_o, axis_tdata_o, line_cnt_o, err_len_o, err_ovf_o);
        end
        rstn_i = 1'b1;
        exp_q.delete();
        m_pix = 0; m_line = 0;
        fd0 = fd_cnt;
        for (int l = 0; l < NL; l++) send_line(NP, 8'(8'h90 + l), 1'b1, 3);
        drain("midreset");
        tests++;
        if (fd_cnt - fd0 != 1 || err_len_o !== 1'b0 || err_ovf_o !== 1'b0) begin
            fails++;
            $display("FAIL midreset_frame: got done=%0d el=%b eo=%b want 1 0 0", fd_cnt - fd0, err_len_o, err_ovf_o);
        end
    endtask

    task automatic test_tkeep();
        do_reset();
        axis_tready_i = 1'b1;
        for (int i = 0; i < 2 * NP; i++)
            beat(i[0] ? 8'(i) : 8'hEE, i[0] ? (i == 2 * NP - 1) : 1'b1, i[0], 1'b1);
        idle(2);
        tests++;
        if (err_len_o !== 1'b0 || line_cnt_o !== 16'd1) begin
            fails++;
            $display("FAIL tkeep_line: got el=%b lc=%0d want 0 1", err_len_o, line_cnt_o);
        end
        drain("tkeep");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_frame();
        test_back_to_back();
        test_overflow();
        test_short_line();
        test_long_line();
        test_mid_reset();
        test_tkeep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
